// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared definitions for the HTIF PCR port arbiter: FSM encoding, widths
// and the read-only CSR region decode.
package vscale_htif_pcr_arbiter_pkg;

    localparam int CSR_ADDR_WIDTH = 12;
    localparam int HTIF_PCR_WIDTH = 64;

    localparam logic [1:0] CSR_RO_REGION = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    function automatic logic is_ro_write(input logic rw, input logic [1:0] region);
        return rw && (region == CSR_RO_REGION);
    endfunction

endpackage

// File: rtl/vscale_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module vscale_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    always_comb begin
        int j;
        logic [IDX_W-1:0] jj;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        j         = 0;
        jj        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = IDX_W'(j);
            if (!gnt_valid && req[jj]) begin
                gnt_valid = 1'b1;
                gnt[jj]   = 1'b1;
                gnt_idx   = jj;
            end
        end
    end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares the CSR file's HTIF PCR port between NUM_REQ requesters, one
// transaction at a time, rejecting writes to the read-only CSR region locally.
module vscale_htif_pcr_arbiter
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = CSR_ADDR_WIDTH,
    parameter int DATA_WIDTH = HTIF_PCR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic                          pcr_req_valid,
    input  logic                          pcr_req_ready,
    output logic                          pcr_req_rw,
    output logic [ADDR_WIDTH-1:0]         pcr_req_addr,
    output logic [DATA_WIDTH-1:0]         pcr_req_data,
    input  logic                          pcr_resp_valid,
    output logic                          pcr_resp_ready,
    input  logic [DATA_WIDTH-1:0]         pcr_resp_data,
    output arb_state_t                    dbg_state,
    output logic [$clog2(NUM_REQ)-1:0]    dbg_rr_ptr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Handshakes: a transfer happens on a clk edge where valid && ready are
    // both high; valid never waits on ready, ready may depend on valid.

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        rr_ptr_q, owner_q, gnt_idx, gnt_next;
    logic                    resp_err_q;
    logic [DATA_WIDTH-1:0]   resp_buf_q;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic                    gnt_valid, idle_gnt, accept, accept_illegal;
    logic                    sel_rw, sel_illegal;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    vscale_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .gnt       (gnt_oh),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    assign sel_rw      = req_rw[gnt_idx];
    assign sel_addr    = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data    = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_illegal = is_ro_write(sel_rw, sel_addr[ADDR_WIDTH-1 -: 2]);
    assign idle_gnt    = reset_n && (state_q == ARB_IDLE) && gnt_valid;
    assign gnt_next    = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);

    always_comb begin
        state_d        = state_q;
        req_ready      = '0;
        pcr_req_valid  = 1'b0;
        pcr_req_rw     = 1'b0;
        pcr_req_addr   = '0;
        pcr_req_data   = '0;
        accept         = 1'b0;
        accept_illegal = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (idle_gnt) begin
                    if (sel_illegal) begin
                        req_ready      = gnt_oh;
                        accept_illegal = 1'b1;
                        state_d        = ARB_RESP;
                    end else begin
                        pcr_req_valid = 1'b1;
                        pcr_req_rw    = sel_rw;
                        pcr_req_addr  = sel_addr;
                        pcr_req_data  = sel_data;
                        if (pcr_req_ready) begin
                            req_ready = gnt_oh;
                            accept    = 1'b1;
                            state_d   = ARB_WAIT;
                        end
                    end
                end
            end
            ARB_WAIT: if (pcr_resp_valid) state_d = ARB_RESP;
            ARB_RESP: if (resp_ready[owner_q]) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // Responses are steered to the owner only; resp_ready of others is ignored.
    assign resp_valid     = (reset_n && state_q == ARB_RESP) ?
                            ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign resp_data      = resp_buf_q;
    assign resp_err       = resp_err_q;
    assign pcr_resp_ready = !reset_n || (state_q == ARB_WAIT);
    assign dbg_state      = state_q;
    assign dbg_rr_ptr     = rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            resp_err_q <= 1'b0;
            resp_buf_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept || accept_illegal) begin
                rr_ptr_q   <= gnt_next;
                owner_q    <= gnt_idx;
                resp_err_q <= accept_illegal;
            end
            if (accept_illegal) begin
                resp_buf_q <= '0;
            end else if (state_q == ARB_WAIT && pcr_resp_valid) begin
                resp_buf_q <= pcr_resp_data;
            end
        end
    end

endmodule

// File: doc/vscale_htif_pcr_arbiter.md
Name: vscale_htif_pcr_arbiter

Overview:
- Shares the single HTIF PCR request/response port of the CSR file between NUM_REQ host-side requesters, for example the HTIF bridge and the debug module.
- Round-robin arbitration, one outstanding transaction at a time.
- The response is routed back to the requester that owns the transaction.
- Writes to the read-only CSR region (addr[11:10]==2'b11) are rejected locally with an error response and are never forwarded.
- Sits between the host-side requesters and the CSR file's htif_pcr_* ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 12, CSR address width (matches CSR_ADDR_WIDTH).
- DATA_WIDTH, 64, PCR data width (matches HTIF_PCR_WIDTH).

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester request accepted
- req_rw  input  NUM_REQ  1 = write
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened; requester i occupies [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  flattened write data
- resp_valid  output  NUM_REQ  per-requester response valid
- resp_ready  input  NUM_REQ  per-requester response accept
- resp_data  output  DATA_WIDTH  shared response data; meaningful only with resp_valid
- resp_err  output  1  response is an error (rejected write)
- pcr_req_valid  output  1  to CSR file htif_pcr_req_valid
- pcr_req_ready  input  1  from CSR file
- pcr_req_rw  output  1  to CSR file
- pcr_req_addr  output  ADDR_WIDTH  to CSR file
- pcr_req_data  output  DATA_WIDTH  to CSR file
- pcr_resp_valid  input  1  from CSR file
- pcr_resp_ready  output  1  to CSR file
- pcr_resp_data  input  DATA_WIDTH  from CSR file

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, rr_ptr=0, owner=0, resp_err=0, resp buffer=0.
  - req_ready, resp_valid and pcr_req_valid are all 0.
  - pcr_resp_ready=1 while reset_n is low, so a stranded CSR response drains.
  - Reset mid-transaction abandons the transaction; no response is delivered.
- States: IDLE, WAIT, RESP.
- Grant (IDLE only, combinational): gnt is the first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ. No valid request means no grant.
- IDLE with grant g, request illegal (req_rw[g] && req_addr[g][11:10]==2'b11):
  - req_ready[g]=1 and pcr_req_valid=0.
  - Next: owner<=g, resp_err<=1, resp buffer<=0, state<=RESP.
- IDLE with grant g, request legal:
  - pcr_req_valid=1; pcr_req_rw/addr/data = requester g's fields.
  - req_ready[g]=pcr_req_ready.
  - On the handshake: owner<=g, resp_err<=0, state<=WAIT.
  - Without the handshake: stay in IDLE. The grant is re-evaluated next cycle (the same g while it stays valid and rr_ptr is unchanged).
- rr_ptr update: on any accepted request, rr_ptr <= (g+1) mod NUM_REQ. It is unchanged otherwise.
- WAIT:
  - pcr_req_valid=0, pcr_resp_ready=1, all req_ready=0.
  - On pcr_resp_valid: resp buffer<=pcr_resp_data, state<=RESP.
- RESP:
  - resp_valid[owner]=1; other bits 0. resp_data=buffer.
  - pcr_resp_ready=0.
  - On resp_ready[owner]: state<=IDLE. No new grant is issued in the same cycle.
- pcr_resp_ready is 1 only in WAIT or during reset.
- Latency, legal request accepted in cycle t against a CSR file that is idle:
  - The CSR file raises resp_valid at t+1.
  - The arbiter presents resp_valid at t+2.
  - The earliest next grant is in the cycle after the resp handshake.
- Illegal request accepted at t: resp_valid at t+1 with resp_err=1 and resp_data=0.
- pcr_req_* is driven only in IDLE. At most one pcr_req_valid handshake per transaction.
- Simultaneous events:
  - All requesters valid: strict rotation, so no requester waits more than NUM_REQ-1 transactions.
  - Requester dropping valid before acceptance is legal; the grant moves on.
- pcr_resp_valid outside WAIT is ignored, except during reset, where it is drained.

Decomposition:
- Shared package/header: state encodings (ARB_IDLE=0, ARB_WAIT=1, ARB_RESP=2) and the read-only region constant CSR_RO_REGION=2'b11.
- Existing CSR_ADDR_WIDTH and HTIF_PCR_WIDTH are reused for the defaults.
- One sub-module: vscale_rr_arbiter.
  - Inputs: NUM_REQ-wide request vector and pointer.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational; reusable for other shared ports.

Test Plan:
- Single read: req0 reads 0x780 with CSR to_host=0x1234 -> pcr_req_valid at t, resp_valid[0] at t+2, resp_data=0x1234, resp_err=0.
- Round-robin: req0 and req1 continuously valid for 4 transactions from reset -> grant order 0,1,0,1; rr_ptr toggles after each accept.
- Read-only write: req1 writes 0xC00 data 5 -> pcr_req_valid never asserts, resp_valid[1] next cycle, resp_err=1, resp_data=0; cycle CSR unchanged.
- Response backpressure: hold resp_ready[0]=0 for 5 cycles -> resp_valid[0] and resp_data stable; req1 valid throughout gets no req_ready until 1 cycle after release.
- Write-then-read: req0 writes 0x781 (from_host) = 0xAB, then req1 reads 0x781 -> req1 receives 0xAB.
- Reset mid-op: reset_n low during WAIT -> next cycle all resp_valid=0, pcr_resp_ready=1, rr_ptr=0; a fresh req1 read after reset completes normally.
